// File: rtl/galois_sub_serial.sv
// Limb-serial modular subtractor: diff = (num1 - num2) mod PRIME_MODULUS.
// One LIMB_BITS slice per cycle: an L-cycle borrow pass, then an L-cycle conditional add-back of p.
`timescale 1ns/1ps
module galois_sub_serial #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                LIMB_BITS     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] num1,
    input  logic [N_BITS-1:0] num2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] diff
);

    localparam int L     = (N_BITS + LIMB_BITS - 1) / LIMB_BITS;
    localparam int W     = L * LIMB_BITS;
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(L - 1);
    localparam logic [W-1:0]     P_PAD = W'(PRIME_MODULUS);

    typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_FIX, ST_DONE} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // out_valid/diff hold steady until that edge, in_ready is high only in IDLE.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       r_q, r_d;
    logic               cy_q, cy_d;
    logic               neg_q, neg_d;

    int                 limb_off;
    logic [LIMB_BITS-1:0] a_limb, b_limb, r_limb, p_limb;
    logic [LIMB_BITS:0]   sub_sum, fix_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cy_q    <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cy_q    <= cy_d;
            neg_q   <= neg_d;
        end
    end

    // cy_q is the borrow during SUB and the carry during FIX; it is cleared between passes.
    always_comb begin
        limb_off = int'(idx_q) * LIMB_BITS;
        a_limb   = a_q[limb_off +: LIMB_BITS];
        b_limb   = b_q[limb_off +: LIMB_BITS];
        r_limb   = r_q[limb_off +: LIMB_BITS];
        p_limb   = neg_q ? P_PAD[limb_off +: LIMB_BITS] : '0;
        sub_sum  = {1'b0, a_limb} - {1'b0, b_limb} - (LIMB_BITS + 1)'(cy_q);
        fix_sum  = {1'b0, r_limb} + {1'b0, p_limb} + (LIMB_BITS + 1)'(cy_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cy_d    = cy_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d                = '0;
                    b_d                = '0;
                    a_d[N_BITS-1:0]    = num1;
                    b_d[N_BITS-1:0]    = num2;
                    idx_d              = '0;
                    cy_d               = 1'b0;
                    neg_d              = 1'b0;
                    state_d            = ST_SUB;
                end
            end
            ST_SUB: begin
                r_d[limb_off +: LIMB_BITS] = sub_sum[LIMB_BITS-1:0];
                cy_d                       = sub_sum[LIMB_BITS];
                if (idx_q == LAST) begin
                    neg_d   = sub_sum[LIMB_BITS];
                    cy_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_FIX: begin
                // Adding zero when neg=0 keeps the operation time data-independent.
                r_d[limb_off +: LIMB_BITS] = fix_sum[LIMB_BITS-1:0];
                cy_d                       = fix_sum[LIMB_BITS];
                if (idx_q == LAST) begin
                    cy_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        diff      = r_q[N_BITS-1:0];
    end

endmodule

// File: tb/tb_galois_sub_serial.sv
// Bench for galois_sub_serial: directed vectors, backpressure, mid-operation reset,
// and randomized operations scored against a plain-arithmetic (a - b) mod p model.
`timescale 1ns/1ps
module tb_galois_sub_serial;

    localparam int N = 254;
    localparam logic [255:0] P = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;

    int checks   = 0;
    int failures = 0;
    logic [255:0] exp_q[$];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [255:0] e;
        string        name;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    galois_sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] ref_sub(input logic [255:0] a, input logic [255:0] b);
        if (a >= b) return a - b;
        return a + P - b;
    endfunction

    function automatic logic [N-1:0] rand_elem();
        logic [255:0] x;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        x[255:254] = 2'b00;
        while (x >= P) x = x - P;
        return x[N-1:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                          input bit pulse, input bit rnd_ready, input string name);
        logic [N-1:0] got;
        int lat;
        check({name, ".in_ready_pre"}, 256'(in_ready), 256'd1);
        num1     = a;
        num2     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        num1     = rand_elem();
        num2     = rand_elem();
        check({name, ".in_ready_busy"}, 256'(in_ready), 256'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check({name, ".latency"}, 256'(lat), 256'd8);
        got = diff;
        check({name, ".diff"}, 256'(diff), exp_q.pop_front());
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = pulse && (h == 1);
            if (in_valid) begin
                num1 = 254'd99;
                num2 = 254'd1;
            end
            check({name, ".hold_valid"}, 256'(out_valid), 256'd1);
            check({name, ".hold_diff"}, 256'(diff), 256'(got));
            check({name, ".hold_in_ready"}, 256'(in_ready), 256'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".in_ready_post"}, 256'(in_ready), 256'd1);
        check({name, ".valid_post"}, 256'(out_valid), 256'd0);
    endtask

    task automatic reset_mid(input int at_edge, input string name);
        int seen;
        num1     = 254'd100;
        num2     = 254'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (at_edge) @(negedge clk);
        rst = 1'b1;
        #1;
        check({name, ".in_ready"}, 256'(in_ready), 256'd1);
        check({name, ".out_valid"}, 256'(out_valid), 256'd0);
        check({name, ".diff"}, 256'(diff), 256'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check({name, ".no_output"}, 256'(seen), 256'd0);
    endtask

    initial begin
        logic [N-1:0] ra, rb;

        vecs[0] = '{254'd5, 254'd3, 256'd2, "5m3"};
        vecs[1] = '{254'd3, 254'd5,
                    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593efffffff, "3m5"};
        vecs[2] = '{254'd0, 254'd0, 256'd0, "0m0"};
        vecs[3] = '{254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000000, 254'd0,
                    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000000, "pm1m0"};
        vecs[4] = '{254'd0, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000000,
                    256'd1, "0mpm1"};
        vecs[5] = '{254'h123456789abcdef0112233445566778899aabbccddeeff00, 254'h123456789abcdef0112233445566778899aabbccddeeff00,
                    256'd0, "xmx"};
        vecs[6] = '{254'h10000000000000000, 254'd1, 256'hffffffffffffffff, "limb_borrow"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num1      = '0;
        num2      = '0;
        #1;
        check("reset.in_ready", 256'(in_ready), 256'd1);
        check("reset.out_valid", 256'(out_valid), 256'd0);
        check("reset.diff", 256'(diff), 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].e);
            run_op(vecs[i].a, vecs[i].b, 0, 1'b0, 1'b0, vecs[i].name);
        end

        exp_q.push_back(256'd7);
        run_op(254'd11, 254'd4, 5, 1'b1, 1'b0, "backpressure");
        exp_q.push_back(256'd19);
        run_op(254'd20, 254'd1, 0, 1'b0, 1'b0, "after_bp");

        reset_mid(2, "rst_sub");
        reset_mid(6, "rst_fix");
        exp_q.push_back(256'd5);
        run_op(254'd7, 254'd2, 0, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 200; i++) begin
            ra = rand_elem();
            rb = ($urandom_range(0, 15) == 0) ? ra : rand_elem();
            exp_q.push_back(ref_sub(256'(ra), 256'(rb)));
            run_op(ra, rb, $urandom_range(0, 3), 1'b0, 1'b1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
